instruction_fetch_unit: RTL and testbench

//  - Owns the PC register and fetches instructions from an instruction memory that may take several cycles per access.
//  - Presents each fetched instruction, and its OpCode, to the control unit for exactly one EXEC cycle.
//  - Applies the control unit's PCWre/PCSrc decision at the end of that cycle.
//  - Sits directly upstream of the control unit; a halt (PCWre=0) or a memory timeout freezes fetch until reset.

---
 rtl/cpu_defs_pkg.sv | 29 ++
 rtl/instruction_fetch_unit_next_pc_calc.sv | 25 ++
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs_pkg.sv
// Definitions shared by the fetch unit and the control unit: word width,
// opcodes, PCSrc encodings and the fetch FSM state type.
package cpu_defs_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  typedef enum logic [2:0] {
    FETCH_REQ,
    FETCH_WAIT,
    FETCH_EXEC,
    FETCH_HALT,
    FETCH_FAULT
  } fetchState_t;

endpackage

// File: rtl/instruction_fetch_unit_next_pc_calc.sv
// Combinational next-PC selection. The reserved PCSrc code falls back to the
// sequential path, and the result is always word aligned.
module next_pc_calc
  import cpu_defs_pkg::*;
(
  input  logic [WORD_W-1:0] pcPlus4,
  input  logic [WORD_W-1:0] extImm,
  input  logic [25:0]       jumpTarget,
  input  logic [1:0]        pcSrc,
  output logic [WORD_W-1:0] nextPc
);

  logic [WORD_W-1:0] rawPc;

  always_comb begin
    rawPc = pcPlus4;
    case (pcSrc)
      PCSRC_BR:  rawPc = pcPlus4 + (extImm << 2);
      PCSRC_JMP: rawPc = {pcPlus4[31:28], jumpTarget, 2'b00};
      default:   rawPc = pcPlus4;
    endcase
    nextPc = {rawPc[WORD_W-1:2], 2'b00};
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns PC/IR, runs the REQ/WAIT/EXEC fetch loop
// against a variable-latency memory, and freezes on halt or memory timeout.
module instruction_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int                MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              PCWre,
  input  logic [1:0]        PCSrc,
  input  logic [WORD_W-1:0] ExtImm,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [WORD_W-1:0] imem_rdata,
  output logic [WORD_W-1:0] IR,
  output logic [5:0]        OpCode,
  output logic              InsValid,
  output logic [WORD_W-1:0] PC,
  output logic [WORD_W-1:0] PC4,
  output logic              Halted,
  output logic              ImemFault
);

  // Count value seen on the last permitted WAIT cycle without ready.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  fetchState_t       state;
  logic [7:0]        waitCnt;
  logic [WORD_W-1:0] nextPc;

  assign imem_addr = PC;
  assign PC4       = PC + 32'd4;
  assign OpCode    = IR[31:26];

  next_pc_calc uNextPc (
    .pcPlus4   (PC4),
    .extImm    (ExtImm),
    .jumpTarget(IR[25:0]),
    .pcSrc     (PCSrc),
    .nextPc    (nextPc)
  );

  // Outputs are registered alongside the state, so each one is set on the
  // edge that enters the state it belongs to.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state     <= FETCH_REQ;
      PC        <= RESET_PC;
      IR        <= '0;
      waitCnt   <= '0;
      imem_req  <= 1'b0;
      InsValid  <= 1'b0;
      Halted    <= 1'b0;
      ImemFault <= 1'b0;
    end else begin
      case (state)
        FETCH_REQ: begin
          waitCnt  <= '0;
          imem_req <= 1'b1;
          state    <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_ready) begin
            IR       <= imem_rdata;
            imem_req <= 1'b0;
            InsValid <= 1'b1;
            state    <= FETCH_EXEC;
          end else if (waitCnt == WAIT_LAST) begin
            imem_req  <= 1'b0;
            Halted    <= 1'b1;
            ImemFault <= 1'b1;
            state     <= FETCH_FAULT;
          end else begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        FETCH_EXEC: begin
          InsValid <= 1'b0;
          if (PCWre) begin
            PC       <= nextPc;
            imem_req <= 1'b1;
            state    <= FETCH_REQ;
          end else begin
            Halted <= 1'b1;
            state  <= FETCH_HALT;
          end
        end
        FETCH_HALT, FETCH_FAULT: begin
          state <= state;
        end
        default: begin
          imem_req  <= 1'b0;
          InsValid  <= 1'b0;
          Halted    <= 1'b1;
          ImemFault <= 1'b1;
          state     <= FETCH_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a queue of expected fetch
// addresses is filled when each EXEC decision is driven and drained per fetch.
module tb_instruction_fetch_unit;
  import cpu_defs_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        PCWre = 1'b1;
  logic [1:0]  PCSrc = 2'b00;
  logic [31:0] ExtImm = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] IR;
  logic [5:0]  OpCode;
  logic        InsValid;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        Halted;
  logic        ImemFault;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] expAddrQ[$];
  logic [31:0] expPc;
  logic [31:0] lastIr;
  bit          fromReset;
  int          lastReqCycles;

  instruction_fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(15)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .PCWre     (PCWre),
    .PCSrc     (PCSrc),
    .ExtImm    (ExtImm),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .IR        (IR),
    .OpCode    (OpCode),
    .InsValid  (InsValid),
    .PC        (PC),
    .PC4       (PC4),
    .Halted    (Halted),
    .ImemFault (ImemFault)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelNext(input logic [31:0] pc, input logic [31:0] ir,
                                            input logic [1:0] src, input logic [31:0] ext);
    logic [31:0] seq;
    logic [31:0] t;
    seq = pc + 32'd4;
    case (src)
      2'b01:   t = seq + (ext << 2);
      2'b10:   t = {seq[31:28], ir[25:0], 2'b00};
      default: t = seq;
    endcase
    return t & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] branchImm(input logic [31:0] pc, input logic [31:0] target);
    return (target - (pc + 32'd4)) >> 2;
  endfunction

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic doReset(input logic rdyDuring, input logic [31:0] rdataDuring);
    Reset = 1'b1;
    imem_ready = rdyDuring;
    imem_rdata = rdataDuring;
    tick();
    checkOutput("rstReq", imem_req, 0);
    checkOutput("rstInsValid", InsValid, 0);
    checkOutput("rstHalted", Halted, 0);
    checkOutput("rstFault", ImemFault, 0);
    checkOutput("rstPc", PC, RESET_PC);
    checkOutput("rstIr", IR, 0);
    Reset = 1'b0;
    imem_ready = 1'b0;
    expPc = RESET_PC;
    expAddrQ.push_back(RESET_PC);
    fromReset = 1'b1;
  endtask

  // Called at the falling edge of a REQ cycle; returns at the falling edge
  // after EXEC (REQ again, or HALT when wre=0).
  task automatic applyStimulus(input logic [31:0] instr, input int idleCycles,
                               input logic wre, input logic [1:0] src, input logic [31:0] ext);
    logic [31:0] expAddr;
    int reqCycles;
    reqCycles = 0;
    checkOutput("reqInReq", imem_req, fromReset ? 0 : 1);
    if (imem_req === 1'b1) reqCycles++;
    fromReset = 1'b0;
    tick();
    if (expAddrQ.size() == 0) begin
      checkOutput("sbUnderflow", 1, 0);
      expAddr = expPc;
    end else begin
      expAddr = expAddrQ.pop_front();
    end
    checkOutput("fetchAddr", imem_addr, expAddr);
    for (int i = 0; i < idleCycles; i++) begin
      checkOutput("waitReq", imem_req, 1);
      checkOutput("waitAddr", imem_addr, expAddr);
      checkOutput("waitInsValid", InsValid, 0);
      if (imem_req === 1'b1) reqCycles++;
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      tick();
    end
    checkOutput("readyReq", imem_req, 1);
    checkOutput("readyAddr", imem_addr, expAddr);
    if (imem_req === 1'b1) reqCycles++;
    lastReqCycles = reqCycles;
    imem_ready = 1'b1;
    imem_rdata = instr;
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    checkOutput("execInsValid", InsValid, 1);
    checkOutput("execIr", IR, instr);
    checkOutput("execOpCode", OpCode, instr[31:26]);
    checkOutput("execReq", imem_req, 0);
    checkOutput("execPc", PC, expPc);
    checkOutput("execPc4", PC4, expPc + 32'd4);
    checkOutput("execHalted", Halted, 0);
    PCWre = wre;
    PCSrc = src;
    ExtImm = ext;
    lastIr = instr;
    if (wre) begin
      expPc = modelNext(expPc, instr, src, ext);
      expAddrQ.push_back(expPc);
    end
    tick();
    PCWre = 1'b1;
    PCSrc = 2'($urandom);
    ExtImm = $urandom;
    checkOutput("postInsValid", InsValid, 0);
    checkOutput("postHalted", Halted, wre ? 0 : 1);
    checkOutput("postPc", PC, expPc);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge CLK);
    doReset(1'b0, 32'h0);

    // Sequential fetches 0,4,8,C then on to 0x10.
    for (int i = 0; i < 4; i++)
      applyStimulus({OP_ADDI, 26'(i)}, 0, 1'b1, 2'b00, $urandom);
    checkOutput("seqPc", PC, 32'h10);

    applyStimulus({OP_BEQ, 26'h1}, 0, 1'b1, 2'b01, 32'hFFFF_FFFE);
    checkOutput("brBackPc", PC, 32'h0C);
    applyStimulus({OP_ADDI, 26'h2}, 0, 1'b1, 2'b00, 32'h0);
    applyStimulus({OP_BEQ, 26'h3}, 0, 1'b1, 2'b01, 32'h3);
    checkOutput("brFwdPc", PC, 32'h20);

    applyStimulus({OP_BEQ, 26'h4}, 0, 1'b1, 2'b01, branchImm(32'h20, 32'h4000_0000));
    checkOutput("brFarPc", PC, 32'h4000_0000);
    applyStimulus({OP_J, 26'h000_0040}, 0, 1'b1, 2'b10, 32'h1234_5678);
    checkOutput("jmpPc", PC, 32'h4000_0100);
    applyStimulus({OP_LW, 26'h3FF_FFFF}, 0, 1'b1, 2'b11, 32'h7777_7777);
    checkOutput("reservedSrcPc", PC, 32'h4000_0104);

    applyStimulus({OP_BEQ, 26'h5}, 0, 1'b1, 2'b01, branchImm(32'h4000_0104, 32'hFFFF_FFFC));
    checkOutput("topPc", PC, 32'hFFFF_FFFC);
    applyStimulus({OP_SW, 26'h6}, 0, 1'b1, 2'b00, 32'h0);
    checkOutput("wrapPc", PC, 32'h0);

    // Slow memory: ready five cycles after the request, then at the last
    // allowed WAIT cycle where ready must beat the timeout.
    applyStimulus({OP_RTYPE, 26'h7}, 4, 1'b1, 2'b00, 32'h0);
    checkOutput("reqHeldCycles", lastReqCycles, 6);
    applyStimulus({OP_RTYPE, 26'h8}, 14, 1'b1, 2'b00, 32'h0);
    checkOutput("readyWinsPc", PC, 32'h8);

    applyStimulus({OP_HALT, 26'h0}, 0, 1'b0, 2'b01, 32'h10);
    for (int i = 0; i < 4; i++) begin
      imem_ready = 1'b1;
      imem_rdata = $urandom;
      checkOutput("haltReq", imem_req, 0);
      checkOutput("haltFlag", Halted, 1);
      checkOutput("haltFault", ImemFault, 0);
      checkOutput("haltPc", PC, 32'h8);
      checkOutput("haltIr", IR, lastIr);
      tick();
    end

    // Memory never answers: fault after 15 WAIT cycles.
    doReset(1'b0, 32'h0);
    checkOutput("faultReqInReq", imem_req, 0);
    tick();
    checkOutput("faultAddr", imem_addr, expAddrQ.pop_front());
    for (int i = 0; i < 15; i++) begin
      checkOutput("faultPendingReq", imem_req, 1);
      checkOutput("faultPendingFlag", ImemFault, 0);
      imem_ready = 1'b0;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput("faultFlag", ImemFault, 1);
      checkOutput("faultHalted", Halted, 1);
      checkOutput("faultReq", imem_req, 0);
      imem_ready = 1'b1;
      tick();
    end

    // Reset during WAIT with stale data on the reset edge.
    doReset(1'b0, 32'h0);
    applyStimulus({OP_ADDI, 26'h9}, 0, 1'b1, 2'b00, 32'h0);
    tick();
    checkOutput("midWaitAddr", imem_addr, expAddrQ.pop_front());
    imem_ready = 1'b0;
    tick();
    doReset(1'b1, 32'hDEAD_BEEF);
    applyStimulus({OP_LW, 26'hA}, 0, 1'b0, 2'b00, 32'h0);
    checkOutput("sbEmpty", expAddrQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
